// File: rtl/seq_pkg.sv
// Shared definitions for the 1111 detector family: transmitter FSM states,
// the default run length and a counter-width helper.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Run length shared with the seq_1111 detector.
    localparam int RUN_DEFAULT = 4;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/seq_run_model.sv
// Golden non-overlapping Mealy run detector. It tracks consecutive ones on a
// qualified serial stream and flags the bit that completes a run of RUN ones.
// After a hit the count restarts, so overlapping runs are not reported.
module seq_run_model
    import seq_pkg::*;
#(
    parameter int RUN = RUN_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic valid,
    input  logic bit_in,
    output logic z
);

    localparam int             CW   = cnt_width(RUN);
    localparam logic [CW-1:0]  LAST = CW'(RUN - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_n_s;

    // Next ones count: clear on load, reset on a zero or a completed run.
    always_comb begin
        cnt_n_s = cnt_r;
        if (clear) begin
            cnt_n_s = '0;
        end else if (valid) begin
            if (!bit_in) begin
                cnt_n_s = '0;
            end else if (cnt_r == LAST) begin
                cnt_n_s = '0;
            end else begin
                cnt_n_s = cnt_r + CW'(1);
            end
        end else begin
            cnt_n_s = cnt_r;
        end
    end

    // Ones-counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_n_s;
        end
    end

    assign z = valid & bit_in & (cnt_r == LAST);

endmodule

// File: rtl/seq_1111_tx.sv
// Serial stimulus transmitter for the seq_1111 detector. A word accepted on
// load&ready is shifted out MSB-first repeat_in+1 times back to back, with
// z_exp marking each bit where the detector must fire.
module seq_1111_tx
    import seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RUN   = RUN_DEFAULT,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] repeat_in,
    input  logic             load,
    output logic             ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             z_exp,
    output logic             done
);

    localparam int            BW       = cnt_width(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    state_t           state_r,  state_n_s;
    logic [WIDTH-1:0] shift_r,  shift_n_s;
    logic [WIDTH-1:0] hold_r,   hold_n_s;
    logic [BW-1:0]    bitcnt_r, bitcnt_n_s;
    logic [CNT_W-1:0] rpt_r,    rpt_n_s;
    logic             ones_clear_s;

    // Next-state and datapath updates for the transmit FSM.
    always_comb begin
        state_n_s    = state_r;
        shift_n_s    = shift_r;
        hold_n_s     = hold_r;
        bitcnt_n_s   = bitcnt_r;
        rpt_n_s      = rpt_r;
        ones_clear_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    shift_n_s    = data_in;
                    hold_n_s     = data_in;
                    rpt_n_s      = repeat_in;
                    bitcnt_n_s   = BIT_LAST;
                    ones_clear_s = 1'b1;
                    state_n_s    = ST_SHIFT;
                end else begin
                    state_n_s    = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bitcnt_r == '0) begin
                    if (rpt_r == '0) begin
                        shift_n_s = shift_r << 1;
                        state_n_s = ST_DONE;
                    end else begin
                        // Reload with no gap bit; the ones count carries over.
                        shift_n_s  = hold_r;
                        bitcnt_n_s = BIT_LAST;
                        rpt_n_s    = rpt_r - CNT_W'(1);
                    end
                end else begin
                    shift_n_s  = shift_r << 1;
                    bitcnt_n_s = bitcnt_r - BW'(1);
                end
            end
            ST_DONE: begin
                state_n_s = ST_IDLE;
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            shift_r  <= '0;
            hold_r   <= '0;
            bitcnt_r <= '0;
            rpt_r    <= '0;
        end else begin
            state_r  <= state_n_s;
            shift_r  <= shift_n_s;
            hold_r   <= hold_n_s;
            bitcnt_r <= bitcnt_n_s;
            rpt_r    <= rpt_n_s;
        end
    end

    // Outputs decode the state register directly, so reset clears them at once.
    assign ready   = (state_r == ST_IDLE);
    assign x_valid = (state_r == ST_SHIFT);
    assign x_out   = x_valid & shift_r[WIDTH-1];
    assign done    = (state_r == ST_DONE);

    seq_run_model #(.RUN(RUN)) u_run (
        .clk    (clk),
        .rst    (rst),
        .clear  (ones_clear_s),
        .valid  (x_valid),
        .bit_in (x_out),
        .z      (z_exp)
    );

endmodule

// File: tb/tb_seq_1111_tx.sv
// Self-checking bench for seq_1111_tx: a stream-level model predicts every
// output cycle, and a single compare process checks the DUT at each negedge.
module tb_seq_1111_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [3:0] repeat_in = 4'h0;
    logic       load = 1'b0;
    logic       ready, x_out, x_valid, z_exp, done;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic r;
        logic v;
        logic x;
        logic z;
        logic d;
    } exp_t;

    exp_t exp_q[$];
    logic chk_en = 1'b0;

    // Model output for the most recent transfer.
    bit mb[128];
    bit mz[128];
    int mlen;

    seq_1111_tx dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .repeat_in (repeat_in),
        .load      (load),
        .ready     (ready),
        .x_out     (x_out),
        .x_valid   (x_valid),
        .z_exp     (z_exp),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Stream model: the word repeated rpt+1 times MSB-first; a hit is any bit
    // closing four ones whose window starts after the previous hit.
    function automatic void build_model(input logic [7:0] w, input int rpt);
        int last_det;
        mlen = 8 * (rpt + 1);
        for (int r = 0; r <= rpt; r++)
            for (int j = 0; j < 8; j++)
                mb[r*8 + j] = w[7-j];
        last_det = -1;
        for (int i = 0; i < mlen; i++) begin
            mz[i] = 1'b0;
            if (i >= 3 && mb[i] && mb[i-1] && mb[i-2] && mb[i-3] && (i - 3) > last_det) begin
                mz[i] = 1'b1;
                last_det = i;
            end
        end
    endfunction

    function automatic logic [31:0] model_z_vec();
        logic [31:0] v = 32'h0;
        for (int i = 0; i < 32 && i < mlen; i++) v[i] = mz[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Compare process: one expected output vector per cycle, idle when empty.
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{r: 1'b1, v: 1'b0, x: 1'b0, z: 1'b0, d: 1'b0};
            check("cycle{ready,x_valid,x_out,z_exp,done}",
                  {27'h0, ready, x_valid, x_out, z_exp, done},
                  {27'h0, e.r, e.v, e.x, e.z, e.d});
        end
    end

    task automatic pin_model(input string name, input logic [7:0] w, input int rpt,
                             input logic [31:0] req);
        build_model(w, rpt);
        check(name, model_z_vec(), req);
    endtask

    // One transfer: hold_ff keeps load=1 with new data during SHIFT;
    // rst_bit > 0 asserts reset just after that bit has been checked.
    task automatic xfer(input logic [7:0] w, input int rpt, input bit hold_ff, input int rst_bit);
        int cycles;
        int total;
        @(negedge clk);
        #1;
        data_in   = w;
        repeat_in = rpt[3:0];
        load      = 1'b1;
        build_model(w, rpt);
        total = mlen;
        for (int i = 0; i < mlen; i++)
            exp_q.push_back('{r: 1'b0, v: 1'b1, x: mb[i], z: mz[i], d: 1'b0});
        exp_q.push_back('{r: 1'b0, v: 1'b0, x: 1'b0, z: 1'b0, d: 1'b1});
        @(posedge clk);
        #1;
        if (hold_ff) begin
            data_in   = 8'hFF;
            repeat_in = 4'hF;
        end else begin
            load      = 1'b0;
            data_in   = 8'($urandom);
            repeat_in = 4'($urandom);
        end
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 400) begin
            @(negedge clk);
            #1;
            cycles++;
            if (hold_ff && exp_q.size() <= 1) load = 1'b0;
            if (rst_bit > 0 && exp_q.size() == total + 1 - rst_bit) begin
                rst = 1'b0;
                exp_q.delete();
                #1;
                check("rst_async{x_valid,z_exp,ready,done}",
                      {28'h0, x_valid, z_exp, ready, done}, 32'h2);
                repeat (2) @(negedge clk);
                #1;
                rst = 1'b1;
            end
        end
        load = 1'b0;
        if (exp_q.size() > 0) begin
            check("xfer_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end
    endtask

    initial begin
        // Pin the model against hand-derived detection positions.
        pin_model("model_F0", 8'hF0, 0, 32'h0000_0008);
        pin_model("model_FF", 8'hFF, 0, 32'h0000_0088);
        pin_model("model_C3x2", 8'hC3, 1, 32'h0000_0200);
        pin_model("model_81x3", 8'h81, 2, 32'h0000_0000);
        pin_model("model_0F", 8'h0F, 0, 32'h0000_0080);

        // Reset state while rst is held low.
        repeat (3) @(negedge clk);
        check("reset{ready,x_valid,x_out,z_exp,done}",
              {27'h0, ready, x_valid, x_out, z_exp, done}, 32'h10);
        #1;
        rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        xfer(8'hF0, 0, 1'b0, 0);
        repeat (2) @(negedge clk);
        xfer(8'hFF, 0, 1'b0, 0);
        check("ones_cnt_after_FF", 32'(dut.u_run.cnt_r), 32'h0);
        xfer(8'hC3, 1, 1'b0, 0);
        xfer(8'h81, 2, 1'b1, 0);
        repeat (2) @(negedge clk);
        xfer(8'hFF, 3, 1'b0, 5);
        repeat (3) @(negedge clk);
        xfer(8'h0F, 0, 1'b0, 0);

        // Randomized transfers with random idle gaps and ignored loads.
        for (int n = 0; n < 14; n++) begin
            xfer(8'($urandom), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_1111_tx.md
Name: seq_1111_tx

Overview:
- Serial stimulus transmitter for the non-overlapping Mealy "1111" detector (seq_1111); drives the far end of its x line.
- Accepts a parallel word through a load/ready handshake and shifts it out MSB-first, one bit per clock, optionally repeated.
- In the same cycle as each bit, asserts z_exp wherever a correct non-overlapping Mealy 1111 detector must assert z. Benches compare z_exp against the detector's z directly.

Parameters:
- WIDTH, 8: bits per transmitted word.
- RUN, 4: consecutive-ones length that triggers a detection.
- CNT_W, 4: width of the repeat count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  word to transmit, MSB first.
- repeat_in  input  CNT_W  extra repetitions; word is sent repeat_in+1 times.
- load  input  1  request to start a transfer.
- ready  output  1  high only in IDLE; a transfer is accepted on a clock edge where load&ready.
- x_out  output  1  serial bit; forced 0 when x_valid=0.
- x_valid  output  1  x_out carries a stream bit this cycle.
- z_exp  output  1  expected detector output for the current bit (Mealy, combinational).
- done  output  1  one-cycle pulse after the last bit of the last repetition.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift register=0, bit counter=0, repeat counter=0, ones counter=0. Outputs: ready=1, x_out=0, x_valid=0, z_exp=0, done=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - On an edge with load=1: capture data_in into both the shift register and a word-hold register; capture repeat_in into the repeat counter; bit counter=WIDTH-1; ones counter=0; next state SHIFT.
- SHIFT:
  - ready=0, x_valid=1, x_out = shift register MSB.
  - Each edge: shift left by 1 and decrement the bit counter.
  - When the bit counter is 0:
    - repeat counter = 0: next state DONE.
    - otherwise: reload the shift register from the word-hold register, bit counter=WIDTH-1, decrement the repeat counter, stay in SHIFT. There is no idle bit between repetitions.
- DONE: done=1 for exactly one cycle, x_valid=0, ready=0; next state IDLE.
- Latency:
  - Load accepted at edge k: first bit valid in the cycle after edge k.
  - Total valid bits = WIDTH*(repeat_in+1), contiguous.
  - done asserts in the cycle after the last bit.
  - ready returns high in the cycle after done.
- load is ignored while not in IDLE. Captured data is not affected by data_in or repeat_in changes after acceptance.
- z_exp (combinational):
  - z_exp = x_valid & x_out & (ones counter == RUN-1).
  - Ones counter update on each edge with x_valid=1:
    - x_out=0: counter = 0.
    - x_out=1 and counter == RUN-1: counter = 0. This is the non-overlap rule.
    - otherwise: counter increments.
  - The counter carries across repetition boundaries.
  - It is cleared only on load acceptance and on reset.
- Counter width is clog2(RUN) bits, minimum 1. repeat_in=0 means a single transmission.
- Reset mid-SHIFT: the transfer is abandoned immediately, x_valid and z_exp drop asynchronously, and no done pulse is issued.

Decomposition:
- Shared package seq_pkg holds:
  - the state enumeration (IDLE, SHIFT, DONE);
  - the default RUN value of 4, shared with seq_1111.
- One natural sub-module, seq_run_model, containing the ones counter and z_exp logic. It can be reused as a golden model in other detector benches.
- Shifter and FSM stay in seq_1111_tx.

Test Plan:
- Word 8'hF0, repeat 0 -> x = 1,1,1,1,0,0,0,0; z_exp=1 on bit 4 only; done pulses the cycle after bit 8; ready=1 the following cycle.
- Word 8'hFF, repeat 0 -> x all 1s; z_exp=1 on bits 4 and 8 only (non-overlap); ones counter=0 at end.
- Word 8'hC3, repeat 1 -> 16 contiguous bits 11000011 11000011; z_exp=1 on bit 10 only (run spans the boundary); no gap bit; done after bit 16.
- Word 8'h81, repeat 2 -> 24 bits; z_exp never asserts (runs of 2); load=1 with data 8'hFF held throughout SHIFT is ignored and the stream is unchanged.
- Word 8'hFF, repeat 3 -> rst=0 asserted during bit 5 drops x_valid, z_exp and ready-blocking immediately; after release: ready=1, no done pulse, and a fresh load of 8'h0F yields z_exp only on bit 8.
